// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared count type, Gray-code helpers and elaboration-time
// constant helpers for the clk_mon frequency monitor.
`timescale 1ns/1ps
package clk_mon_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t bin2gray(input cnt_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic cnt_t gray2bin(input cnt_t gray);
    cnt_t bin;
    bin[CNT_W-1] = gray[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Expected tst_clk edges per window.
  function automatic longint f_exp(input int window_cycles, input int tst_mhz, input int clk_mhz);
    return longint'(window_cycles) * longint'(tst_mhz) / longint'(clk_mhz);
  endfunction

  // Allowed deviation from the expected count.
  function automatic longint f_tol(input longint exp_cnt, input int tol_pct);
    return exp_cnt * longint'(tol_pct) / longint'(100);
  endfunction

endpackage

// File: rtl/clk_mon_gray_sync.sv
// clk_mon_gray_sync: generic-width two-flop synchroniser with asynchronous,
// active-high reset. Only safe for buses where at most one bit changes per
// source clock (Gray codes) or for single-bit level signals.
`timescale 1ns/1ps
module clk_mon_gray_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_mon.sv
// clk_mon: measures tst_clk against the reference clk by counting tst_clk
// edges over fixed windows of clk cycles. tst_ok reports whether the last
// window(s) fell within EXP +/- TOL.
// Optional build macro CLKMON_HYST_EN: tst_ok needs two consecutive good
// windows to rise; any bad window clears it.
`timescale 1ns/1ps
module clk_mon
  import clk_mon_pkg::*;
#(
  parameter int   CLK_MHZ       = 1,
  parameter int   TST_MHZ       = 100,
  parameter int   WINDOW_CYCLES = 1000,
  parameter int   TOL_PCT       = 1,
  parameter cnt_t CNT_INIT      = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tst_clk,
  output logic tst_ok
);

  localparam longint EXP_CNT = f_exp(WINDOW_CYCLES, TST_MHZ, CLK_MHZ);
  localparam longint TOL_CNT = f_tol(EXP_CNT, TOL_PCT);
  localparam cnt_t   LO_CNT  = cnt_t'(EXP_CNT - TOL_CNT);
  localparam cnt_t   HI_CNT  = cnt_t'(EXP_CNT + TOL_CNT);
  localparam int     WIN_W   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic             tst_rel;
  logic             tst_rst;
  cnt_t             tst_cnt;
  cnt_t             tst_gray;
  cnt_t             gray_sync;
  cnt_t             cur_cnt;
  cnt_t             prev_cnt;
  cnt_t             delta;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic             base_vld;
  logic             win_good;
  logic             eval_q;
  logic             good_q;

  // The release flag resets to 0, so the tst_clk-domain reset asserts
  // immediately and only drops after two tst_clk edges.
  clk_mon_gray_sync #(.W(1)) u_rst_sync (
    .clk   (tst_clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (tst_rel)
  );

  assign tst_rst = ~tst_rel;

  // Free-running edge counter plus a registered Gray copy of its value.
  always_ff @(posedge tst_clk or posedge tst_rst) begin
    if (tst_rst) begin
      tst_cnt  <= CNT_INIT;
      tst_gray <= bin2gray(CNT_INIT);
    end else begin
      tst_cnt  <= tst_cnt + cnt_t'(1);
      tst_gray <= bin2gray(tst_cnt + cnt_t'(1));
    end
  end

  clk_mon_gray_sync #(.W(CNT_W)) u_gray_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tst_gray),
    .q     (gray_sync)
  );

  assign cur_cnt = gray2bin(gray_sync);
  assign win_end = (win_cnt == WIN_LAST);

  // Window counter runs 0..WINDOW_CYCLES-1 and wraps.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt <= '0;
    end else if (win_end) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  // Snapshot the count at each window end; the first one is only a baseline.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prev_cnt <= '0;
      base_vld <= 1'b0;
    end else if (win_end) begin
      prev_cnt <= cur_cnt;
      base_vld <= 1'b1;
    end
  end

  // Modulo subtraction keeps the delta correct across counter wrap.
  always_comb begin
    delta    = cur_cnt - prev_cnt;
    win_good = (delta >= LO_CNT) && (delta <= HI_CNT);
  end

  // Capture the window verdict at window end for use on the next clk.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      eval_q <= 1'b0;
      good_q <= 1'b0;
    end else begin
      eval_q <= win_end && base_vld;
      good_q <= win_good;
    end
  end

`ifdef CLKMON_HYST_EN
  logic prev_good;

  // Rise only after two good windows in a row; drop on any bad window.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tst_ok    <= 1'b0;
      prev_good <= 1'b0;
    end else if (eval_q) begin
      prev_good <= good_q;
      tst_ok    <= good_q && prev_good;
    end
  end
`else
  // Follow the verdict of the most recent window.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tst_ok <= 1'b0;
    end else if (eval_q) begin
      tst_ok <= good_q;
    end
  end
`endif

endmodule

// File: tb/tb_clk_mon.sv
// tb_clk_mon: drives tst_clk at directed and random frequencies, one
// frequency per measurement window, and compares tst_ok of two monitors
// (one starting near counter wrap) against a window-level reference model.
// Honours CLKMON_HYST_EN in the same way as the design.
`timescale 1ns/1ps
module tb_clk_mon;

  localparam int CLK_MHZ       = 1;
  localparam int TST_MHZ       = 100;
  localparam int WINDOW_CYCLES = 200;
  localparam int TOL_PCT       = 1;
  localparam int EXP_CNT       = WINDOW_CYCLES * TST_MHZ / CLK_MHZ;
  localparam int TOL_CNT       = EXP_CNT * TOL_PCT / 100;
  localparam real CLK_HALF_NS  = 500.0 / CLK_MHZ;

  logic clk;
  logic rst_n;
  logic tst_clk;
  logic tst_ok;
  logic tst_ok_w;

  int   tst_half_ps;
  int   n_checks;
  int   n_errors;

  int   win_idx;
  logic ok_model;
  logic last_good;
  logic pend_valid;
  logic pend_good;

  clk_mon #(
    .CLK_MHZ       (CLK_MHZ),
    .TST_MHZ       (TST_MHZ),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .TOL_PCT       (TOL_PCT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tst_clk (tst_clk),
    .tst_ok  (tst_ok)
  );

  clk_mon #(
    .CLK_MHZ       (CLK_MHZ),
    .TST_MHZ       (TST_MHZ),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .TOL_PCT       (TOL_PCT),
    .CNT_INIT      (32'hFFFF_8AD0)
  ) dut_wrap (
    .clk     (clk),
    .rst_n   (rst_n),
    .tst_clk (tst_clk),
    .tst_ok  (tst_ok_w)
  );

  initial clk = 1'b0;
  always #(CLK_HALF_NS) clk = ~clk;

  // tst_clk generator; a half period of 0 holds the clock stopped low.
  initial begin
    tst_clk = 1'b0;
    forever begin
      if (tst_half_ps == 0) begin
        tst_clk = 1'b0;
        @(tst_half_ps);
      end else begin
        #(tst_half_ps * 0.001);
        tst_clk = ~tst_clk;
      end
    end
  end

  task automatic check_output(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_freq(input real mhz);
    if (mhz <= 0.0) tst_half_ps = 0;
    else            tst_half_ps = $rtoi(500000.0 / mhz + 0.5);
  endtask

  // Edges produced in one window at the applied frequency, against EXP +/- TOL.
  function automatic logic window_good(input int half_ps);
    real n;
    if (half_ps == 0) return 1'b0;
    n = WINDOW_CYCLES * (1.0e6 / CLK_MHZ) / (2.0 * half_ps);
    return (n >= real'(EXP_CNT - TOL_CNT)) && (n <= real'(EXP_CNT + TOL_CNT));
  endfunction

  // Random target count kept well clear of the tolerance edges.
  function automatic real rand_mhz();
    int dev;
    int n;
    if ($urandom_range(0, 1) == 1) dev = int'($urandom_range(0, TOL_CNT - 30));
    else                           dev = TOL_CNT + 30 + int'($urandom_range(0, TOL_CNT));
    n = ($urandom_range(0, 1) == 1) ? EXP_CNT + dev : EXP_CNT - dev;
    return real'(n) * CLK_MHZ / WINDOW_CYCLES;
  endfunction

  task automatic reset_model();
    win_idx    = 0;
    ok_model   = 1'b0;
    last_good  = 1'b0;
    pend_valid = 1'b0;
    pend_good  = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  // Runs one full window at the given frequency, entered right after a
  // window boundary; checks tst_ok before and after the previous verdict lands.
  task automatic apply_stimulus(input real mhz);
    logic old_ok;
    set_freq(mhz);
    old_ok = ok_model;
    if (pend_valid) begin
`ifdef CLKMON_HYST_EN
      ok_model  = pend_good && last_good;
      last_good = pend_good;
`else
      ok_model  = pend_good;
`endif
    end
    @(negedge clk);
    check_output($sformatf("w%0d_pre", win_idx), tst_ok, old_ok);
    check_output($sformatf("w%0d_pre_wrap", win_idx), tst_ok_w, old_ok);
    @(negedge clk);
    check_output($sformatf("w%0d_post", win_idx), tst_ok, ok_model);
    check_output($sformatf("w%0d_post_wrap", win_idx), tst_ok_w, ok_model);
    repeat (WINDOW_CYCLES - 1) @(posedge clk);
    win_idx++;
    pend_valid = (win_idx >= 2);
    pend_good  = window_good(tst_half_ps);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_model();
    rst_n = 1'b1;
    set_freq(TST_MHZ);

    $display("[TB] reset held with clocks running");
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("reset_hold", tst_ok, 1'b0);
      check_output("reset_hold_wrap", tst_ok_w, 1'b0);
    end

    $display("[TB] nominal frequency from release");
    release_reset();
    repeat (4) apply_stimulus(TST_MHZ);

    $display("[TB] tst_clk stopped");
    repeat (4) apply_stimulus(0.0);

    $display("[TB] slow then slightly fast tst_clk");
    repeat (2) apply_stimulus(98.0);
    repeat (3) apply_stimulus(100.5);

    $display("[TB] reset pulse while locked");
    @(negedge clk);
    check_output("pre_reset", tst_ok, ok_model);
    check_output("pre_reset_wrap", tst_ok_w, ok_model);
    check_output("pre_reset_locked", tst_ok, 1'b1);
    #100 rst_n = 1'b1;
    #1;
    check_output("async_reset", tst_ok, 1'b0);
    check_output("async_reset_wrap", tst_ok_w, 1'b0);
    repeat (3) @(posedge clk);
    reset_model();
    release_reset();
    repeat (3) apply_stimulus(TST_MHZ);

    $display("[TB] random frequencies");
    for (int i = 0; i < 8; i++) apply_stimulus(rand_mhz());
    apply_stimulus(TST_MHZ);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
